// File: rtl/seg7_pkg.sv
// Shared 7-segment code table and scan-decoder state type, used by both the
// hex->segment encoder and the receive-side decoder so the tables cannot diverge.
package seg7_pkg;

  // Active-low segments, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACCUM  = 2'd1,
    LOCKED = 2'd2
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational reverse lookup: active-low segment pattern -> hex nibble,
// flagged as a legal digit, the blank pattern, or neither (bad).
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  // Searching the encoder table itself keeps decode and encode in lock-step.
  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    nibble = 4'h0;
    legal  = 1'b0;
    blank  = (seg_n == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_n == hex_to_seg(4'(i))) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, commits a pattern once it has
// been seen STABLE_CNT times in a row, and keeps a decoded per-digit register file.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 6,
  parameter int STABLE_CNT = 4
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      sample_en,
  input  logic [6:0]                seg_n,
  input  logic [NDIG-1:0]           dig_sel,
  output logic [4*NDIG-1:0]         hex_out,
  output logic [NDIG-1:0]           digit_valid,
  output logic [NDIG-1:0]           bad_pattern,
  output logic                      upd_valid,
  output logic [$clog2(NDIG)-1:0]   upd_idx,
  output logic [3:0]                upd_hex
);

  localparam int IDX_W = $clog2(NDIG);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  scan_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [NDIG+6:0]      last_q;
  logic                 sel_ok, accepted, match, commit;
  logic [IDX_W-1:0]     sel_idx;
  logic [3:0]           lk_nibble;
  logic                 lk_legal, lk_blank;
  logic [3:0]           hex_q [NDIG];

  seg7_lookup u_lookup (
    .seg_n  (seg_n),
    .nibble (lk_nibble),
    .legal  (lk_legal),
    .blank  (lk_blank)
  );

  assign sel_ok   = $onehot(dig_sel);
  assign accepted = sample_en && sel_ok;
  assign match    = ({dig_sel, seg_n} == last_q);
  assign cnt_inc  = cnt + CNT_ONE;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Qualification FSM; a zero or multi-hot select aborts any run in progress.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    if (sample_en) begin
      if (!sel_ok) begin
        state_nxt = EMPTY;
        cnt_nxt   = '0;
      end else begin
        case (state)
          EMPTY: begin
            cnt_nxt = CNT_ONE;
            if (STABLE_CNT == 1) begin
              commit    = 1'b1;
              state_nxt = LOCKED;
            end else begin
              state_nxt = ACCUM;
            end
          end
          ACCUM: begin
            if (match) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                commit    = 1'b1;
                state_nxt = LOCKED;
              end
            end else begin
              cnt_nxt = CNT_ONE;
            end
          end
          LOCKED: begin
            if (!match) begin
              cnt_nxt = CNT_ONE;
              if (STABLE_CNT == 1) begin
                commit = 1'b1;
              end else begin
                state_nxt = ACCUM;
              end
            end
          end
          default: begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= EMPTY;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accepted) last_q <= {dig_sel, seg_n};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_hex   <= 4'h0;
    end else begin
      upd_valid <= commit;
      if (commit) begin
        upd_idx <= sel_idx;
        upd_hex <= lk_legal ? lk_nibble : 4'h0;
      end
    end
  end

  // Register file: only the committing digit's entry is written.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      // NOTE: the register file is small and its reset value is visible on hex_out, so it is reset.
      for (int i = 0; i < NDIG; i++) hex_q[i] <= 4'h0;
      digit_valid <= '0;
      bad_pattern <= '0;
    end else if (commit) begin
      hex_q[sel_idx]       <= lk_legal ? lk_nibble : 4'h0;
      digit_valid[sel_idx] <= lk_legal;
      bad_pattern[sel_idx] <= !lk_legal && !lk_blank;
    end
  end

  always_comb begin
    hex_out = '0;
    for (int i = 0; i < NDIG; i++) hex_out[4*i +: 4] = hex_q[i];
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: default build plus a STABLE_CNT=1 build
// driven from the same bus.
module tb_seg7_scan_decoder;

  localparam int NDIG = 6;

  logic              clk = 1'b0;
  logic              clrn;
  logic              sample_en;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   dig_sel;

  logic [4*NDIG-1:0] hex_out,     s1_hex_out;
  logic [NDIG-1:0]   digit_valid, s1_digit_valid;
  logic [NDIG-1:0]   bad_pattern, s1_bad_pattern;
  logic              upd_valid,   s1_upd_valid;
  logic [2:0]        upd_idx,     s1_upd_idx;
  logic [3:0]        upd_hex,     s1_upd_hex;

  int checks = 0;
  int errors = 0;

  // Hand-written segment table (active-low, bit0=a .. bit6=g).
  localparam logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(4)) u_dut (
    .clk         (clk),
    .clrn        (clrn),
    .sample_en   (sample_en),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_hex     (upd_hex)
  );

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(1)) u_dut1 (
    .clk         (clk),
    .clrn        (clrn),
    .sample_en   (sample_en),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .hex_out     (s1_hex_out),
    .digit_valid (s1_digit_valid),
    .bad_pattern (s1_bad_pattern),
    .upd_valid   (s1_upd_valid),
    .upd_idx     (s1_upd_idx),
    .upd_hex     (s1_upd_hex)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [NDIG-1:0] sel, input logic [6:0] seg);
    sample_en = 1'b1;
    dig_sel   = sel;
    seg_n     = seg;
    tick();
  endtask

  task automatic idle();
    sample_en = 1'b0;
    tick();
  endtask

  logic [23:0] exp_hex;

  initial begin
    clrn      = 1'b0;
    sample_en = 1'b0;
    seg_n     = 7'h7f;
    dig_sel   = '0;

    // 1: reset state, then 4 samples of '2' on digit 0
    tick();
    check("rst_hex_out",     hex_out,     0);
    check("rst_digit_valid", digit_valid, 0);
    check("rst_bad_pattern", bad_pattern, 0);
    check("rst_upd_valid",   upd_valid,   0);
    check("rst_upd_idx",     upd_idx,     0);
    check("rst_upd_hex",     upd_hex,     0);
    check("rst_s1_upd_valid", s1_upd_valid, 0);
    clrn = 1'b1;
    tick();
    smp(6'b000001, 7'b0100100);
    smp(6'b000001, 7'b0100100);
    smp(6'b000001, 7'b0100100);
    check("t1_no_commit_3", upd_valid, 0);
    smp(6'b000001, 7'b0100100);
    check("t1_upd_valid",   upd_valid,   1);
    check("t1_upd_idx",     upd_idx,     0);
    check("t1_upd_hex",     upd_hex,     2);
    check("t1_hex_out",     hex_out,     24'h000002);
    check("t1_digit_valid", digit_valid, 6'b000001);
    smp(6'b000001, 7'b0100100);
    check("t1_no_repulse_5", upd_valid, 0);
    smp(6'b000001, 7'b0100100);
    check("t1_no_repulse_6", upd_valid, 0);

    // 2: broken run on digit 2 restarts the count
    smp(6'b000100, 7'b0110000);
    smp(6'b000100, 7'b0110000);
    smp(6'b000100, 7'b0110000);
    check("t2_no_commit_3", upd_valid, 0);
    smp(6'b000100, 7'b0011001);
    check("t2_mismatch_no_commit", upd_valid, 0);
    smp(6'b000100, 7'b0011001);
    smp(6'b000100, 7'b0011001);
    check("t2_no_commit_3b", upd_valid, 0);
    smp(6'b000100, 7'b0011001);
    check("t2_upd_valid",   upd_valid,   1);
    check("t2_upd_idx",     upd_idx,     2);
    check("t2_upd_hex",     upd_hex,     4);
    check("t2_hex_out",     hex_out,     24'h000402);
    check("t2_digit_valid", digit_valid, 6'b000101);

    // 3: bad pattern then blank on digit 5
    repeat (4) smp(6'b100000, 7'b1010101);
    check("t3_bad_upd_valid",   upd_valid,   1);
    check("t3_bad_upd_idx",     upd_idx,     5);
    check("t3_bad_upd_hex",     upd_hex,     0);
    check("t3_bad_pattern",     bad_pattern, 6'b100000);
    check("t3_bad_digit_valid", digit_valid, 6'b000101);
    check("t3_bad_hex_out",     hex_out,     24'h000402);
    repeat (4) smp(6'b100000, 7'b1111111);
    check("t3_blank_upd_valid",   upd_valid,   1);
    check("t3_blank_upd_hex",     upd_hex,     0);
    check("t3_blank_bad_pattern", bad_pattern, 0);
    check("t3_blank_digit_valid", digit_valid, 6'b000101);

    // 4a: multi-hot select clears a partial count
    smp(6'b000010, 7'b0110000);
    smp(6'b000010, 7'b0110000);
    smp(6'b000011, 7'b0110000);
    check("t4_multihot_no_commit", upd_valid, 0);
    smp(6'b000010, 7'b0110000);
    smp(6'b000010, 7'b0110000);
    smp(6'b000010, 7'b0110000);
    check("t4_cleared_no_commit", upd_valid, 0);
    smp(6'b000010, 7'b0110000);
    check("t4_commit_after_clear", upd_valid, 1);
    check("t4_hex_out_a",          hex_out,   24'h000432);
    check("t4_digit_valid_a",      digit_valid, 6'b000111);

    // 4b: sample_en gaps inside a run do not break it
    smp(6'b001000, 7'b1111000);
    idle();
    smp(6'b001000, 7'b1111000);
    idle();
    idle();
    smp(6'b001000, 7'b1111000);
    check("t4_gap_no_commit_3", upd_valid, 0);
    idle();
    check("t4_gap_idle", upd_valid, 0);
    smp(6'b001000, 7'b1111000);
    check("t4_gap_upd_valid", upd_valid, 1);
    check("t4_gap_upd_idx",   upd_idx,   3);
    check("t4_gap_upd_hex",   upd_hex,   7);
    check("t4_gap_hex_out",   hex_out,   24'h007432);

    // 5: all 16 codes, code k on digit k mod 6
    exp_hex = 24'h007432;
    for (int k = 0; k < 16; k++) begin
      logic [NDIG-1:0] sel;
      int d;
      d   = k % NDIG;
      sel = NDIG'(1) << d;
      repeat (4) smp(sel, SEGTAB[k]);
      exp_hex[4*d +: 4] = 4'(k);
      check($sformatf("t5_upd_hex_%0d", k), upd_hex, k);
      check($sformatf("t5_hex_out_%0d", k), hex_out, exp_hex);
    end
    check("t5_hex_out_final",     hex_out,     24'hBAFEDC);
    check("t5_digit_valid_final", digit_valid, 6'b111111);
    check("t5_bad_pattern_final", bad_pattern, 6'b000000);

    // 6: reset mid-accumulation, then STABLE_CNT=1 behaviour
    smp(6'b010000, 7'b1111001);
    smp(6'b010000, 7'b1111001);
    sample_en = 1'b0;
    clrn      = 1'b0;
    #1;
    check("t6_rst_hex_out",     hex_out,     0);
    check("t6_rst_digit_valid", digit_valid, 0);
    check("t6_rst_upd_valid",   upd_valid,   0);
    check("t6_rst_upd_hex",     upd_hex,     0);
    tick();
    clrn = 1'b1;
    tick();
    smp(6'b010000, 7'b1111001);
    check("t6_s1_first_commit", s1_upd_valid, 1);
    check("t6_s1_first_hex",    s1_upd_hex,   1);
    check("t6_s1_first_idx",    s1_upd_idx,   4);
    smp(6'b010000, 7'b1111001);
    check("t6_s1_match_no_commit", s1_upd_valid, 0);
    smp(6'b010000, 7'b1111001);
    check("t6_no_commit_3", upd_valid, 0);
    smp(6'b010000, 7'b1111001);
    check("t6_commit_4",     upd_valid,   1);
    check("t6_hex_out",      hex_out,     24'h010000);
    check("t6_digit_valid",  digit_valid, 6'b010000);
    smp(6'b000001, 7'b0001000);
    check("t6_s1_mismatch_commit_a", s1_upd_valid, 1);
    check("t6_s1_upd_idx_a",         s1_upd_idx,   0);
    check("t6_s1_upd_hex_a",         s1_upd_hex,   4'hA);
    smp(6'b000001, 7'b0000011);
    check("t6_s1_mismatch_commit_b", s1_upd_valid, 1);
    check("t6_s1_upd_hex_b",         s1_upd_hex,   4'hB);
    check("t6_s1_hex_out",           s1_hex_out,   24'h01000B);
    smp(6'b000101, 7'b0000011);
    check("t6_s1_multihot_no_commit", s1_upd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
